// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: three-byte instruction fetch sequencer; FETCH_REUSE_EN adds a one-entry reuse buffer
module instr_fetch_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] op_code,
  output logic [DATA_W-1:0] arg1,
  output logic [DATA_W-1:0] arg2,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy
`ifdef FETCH_REUSE_EN
  ,
  input  logic              reuse_flush
`endif
);
  typedef enum logic [2:0] {IDLE, F0, F1, F2, W2, HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc_r, pc_n, addr_n;
  logic [DATA_W-1:0] op_n, a1_n, a2_n;
  logic hit;
`ifdef FETCH_REUSE_EN
  logic [ADDR_W-1:0] tag;
  logic [DATA_W-1:0] b_op, b_a1, b_a2;
  logic tag_valid;
  assign hit = tag_valid && !reuse_flush && pc_in == tag;
`else
  assign hit = 1'b0;
`endif
  always_comb begin
    state_n = state;
    pc_n = pc_r;
    if (pc_req) begin
      pc_n = pc_in;
      state_n = hit ? HOLD : F0;
    end else begin
      case (state)
        F0:      state_n = F1;
        F1:      state_n = F2;
        F2:      state_n = W2;
        W2:      state_n = HOLD;
        HOLD:    state_n = instr_ready ? IDLE : HOLD;
        default: state_n = IDLE;
      endcase
    end
    op_n = state == F1 ? mem_rdata : op_code;
    a1_n = state == F2 ? mem_rdata : arg1;
    a2_n = state == W2 ? mem_rdata : arg2;
`ifdef FETCH_REUSE_EN
    op_n = pc_req && hit ? b_op : op_n;
    a1_n = pc_req && hit ? b_a1 : a1_n;
    a2_n = pc_req && hit ? b_a2 : a2_n;
`endif
    addr_n = state_n == F0 ? pc_n :
             state_n == F1 ? pc_r + ADDR_W'(1) :
             state_n == F2 ? pc_r + ADDR_W'(2) : mem_addr;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_r        <= '0;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      op_code     <= '0;
      arg1        <= '0;
      arg2        <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      pc_r        <= pc_n;
      mem_addr    <= addr_n;
      mem_rd      <= state_n == F0 || state_n == F1 || state_n == F2;
      busy        <= state_n == F0 || state_n == F1 || state_n == F2 || state_n == W2;
      instr_valid <= state_n == HOLD;
      op_code     <= op_n;
      arg1        <= a1_n;
      arg2        <= a2_n;
    end
  end
`ifdef FETCH_REUSE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_valid <= 1'b0;
      tag       <= '0;
      b_op      <= '0;
      b_a1      <= '0;
      b_a2      <= '0;
    end else begin
      if (state == W2 && !pc_req) begin
        tag       <= pc_r;
        b_op      <= op_code;
        b_a1      <= arg1;
        b_a2      <= mem_rdata;
        tag_valid <= 1'b1;
      end
      if (reuse_flush) tag_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed and randomized checks against a cycle-age reference model
module tb_instr_fetch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, pc_req = 1'b0, instr_ready = 1'b0, reuse_flush = 1'b0;
  logic [7:0] pc_in = '0, mem_rdata = '0;
  logic [7:0] mem_addr, op_code, arg1, arg2;
  logic mem_rd, instr_valid, busy;
  logic [7:0] mem [256];
  int total = 0, bad = 0;
`ifdef FETCH_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef FETCH_REUSE_EN
    .reuse_flush(reuse_flush),
`endif
    .pc_in(pc_in),
    .pc_req(pc_req),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_rdata(mem_rdata),
    .op_code(op_code),
    .arg1(arg1),
    .arg2(arg2),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .busy(busy)
  );

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: age counts cycles since the request was accepted; 5 means the instruction is on offer.
  int age = 0;
  bit live = 1'b0;
  logic [7:0] mpc = '0, maddr = '0, mop = '0, ma1 = '0, ma2 = '0;
  logic [7:0] mtag = '0, bop = '0, ba1 = '0, ba2 = '0, p1, p2;
  logic mtag_v = 1'b0, mhit;

  always @(posedge clk) begin
    if (!rst_n) begin
      age = 0;
      maddr = '0;
      mtag_v = 1'b0;
      live = 1'b1;
    end else begin
      mhit = REUSE && mtag_v && !reuse_flush && pc_in == mtag;
      if (pc_req) begin
        mpc = pc_in;
        age = mhit ? 5 : 1;
        if (mhit) {mop, ma1, ma2} = {bop, ba1, ba2};
      end else if (age >= 1 && age <= 4) begin
        age++;
        if (age == 5) begin
          p1 = mpc + 8'd1;
          p2 = mpc + 8'd2;
          {mop, ma1, ma2} = {mem[mpc], mem[p1], mem[p2]};
          {mtag, bop, ba1, ba2} = {mpc, mop, ma1, ma2};
          mtag_v = 1'b1;
        end
      end else if (age == 5 && instr_ready) begin
        age = 0;
      end
      if (age >= 1 && age <= 3) maddr = mpc + 8'(age - 1);
      if (reuse_flush) mtag_v = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("mem_rd", {31'd0, mem_rd}, {31'd0, age >= 1 && age <= 3});
      chk("busy", {31'd0, busy}, {31'd0, age >= 1 && age <= 4});
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, age == 5});
      chk("mem_addr", {24'd0, mem_addr}, {24'd0, maddr});
      if (age == 5) begin
        chk("op_code", {24'd0, op_code}, {24'd0, mop});
        chk("arg1", {24'd0, arg1}, {24'd0, ma1});
        chk("arg2", {24'd0, arg2}, {24'd0, ma2});
      end
    end
  end

  task automatic req(input logic [7:0] pc, input logic fl);
    pc_req = 1'b1;
    pc_in = pc;
    reuse_flush = fl;
    @(negedge clk);
    pc_req = 1'b0;
    reuse_flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    {mem[8'h10], mem[8'h11], mem[8'h12]} = {8'hA7, 8'h05, 8'h3C};
    {mem[8'hFE], mem[8'hFF], mem[8'h00]} = {8'h11, 8'h22, 8'h33};
    {mem[8'h20], mem[8'h21], mem[8'h22]} = {8'h5A, 8'h6B, 8'h7C};
    repeat (2) @(negedge clk);
    chk("rst_outs", {mem_rd, instr_valid, busy, mem_addr, op_code}, '0);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    req(8'h10, 1'b1);
    chk("t1_addr0", {24'd0, mem_addr}, 32'h10);
    chk("t1_rd0", {31'd0, mem_rd}, 32'd1);
    @(negedge clk);
    chk("t1_addr1", {24'd0, mem_addr}, 32'h11);
    @(negedge clk);
    chk("t1_addr2", {24'd0, mem_addr}, 32'h12);
    @(negedge clk);
    chk("t1_rd_w2", {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_bytes", {8'd0, op_code, arg1, arg2}, 32'hA7053C);
    @(negedge clk);
    chk("t1_drop", {31'd0, instr_valid}, 32'd0);
    req(8'hFE, 1'b1);
    chk("wrap_a0", {24'd0, mem_addr}, 32'hFE);
    @(negedge clk);
    chk("wrap_a1", {24'd0, mem_addr}, 32'hFF);
    @(negedge clk);
    chk("wrap_a2", {24'd0, mem_addr}, 32'h00);
    repeat (2) @(negedge clk);
    chk("wrap_bytes", {7'd0, instr_valid, op_code, arg1, arg2}, 32'h1112233);
    @(negedge clk);
    instr_ready = 1'b0;
    req(8'h10, 1'b1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold", {7'd0, instr_valid, op_code, arg1, arg2}, 32'h1A7053C);
    end
    @(negedge clk);
    chk("bp_last", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", {30'd0, instr_valid, busy}, 32'd0);
    req(8'h10, 1'b1);
    chk("rd_a0", {24'd0, mem_addr}, 32'h10);
    @(negedge clk);
    chk("rd_a1", {24'd0, mem_addr}, 32'h11);
    req(8'h20, 1'b1);
    chk("rd_a2", {24'd0, mem_addr}, 32'h20);
    @(negedge clk);
    chk("rd_a3", {24'd0, mem_addr}, 32'h21);
    @(negedge clk);
    chk("rd_a4", {24'd0, mem_addr}, 32'h22);
    @(negedge clk);
    chk("rd_novalid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    chk("rd_bytes", {7'd0, instr_valid, op_code, arg1, arg2}, 32'h15A6B7C);
    @(negedge clk);
    req(8'h10, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst", {mem_rd, instr_valid, busy, mem_addr, op_code, arg1, arg2}, '0);
    rst_n = 1'b1;
    req(8'h10, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_rst", {7'd0, instr_valid, op_code, arg1, arg2}, 32'h1A7053C);
    @(negedge clk);
`ifdef FETCH_REUSE_EN
    req(8'h10, 1'b1);
    repeat (4) @(negedge clk);
    @(negedge clk);
    req(8'h10, 1'b0);
    chk("reuse_hit", {6'd0, instr_valid, mem_rd, op_code, arg1, arg2}, 32'h2A7053C);
    @(negedge clk);
    reuse_flush = 1'b1;
    @(negedge clk);
    reuse_flush = 1'b0;
    req(8'h10, 1'b0);
    chk("reuse_miss", {30'd0, instr_valid, mem_rd}, 32'd1);
    repeat (5) @(negedge clk);
`endif
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom % 64) != 0;
      pc_req = ($urandom % 8) == 0;
      case ($urandom % 4)
        0: pc_in = 8'h10;
        1: pc_in = 8'hFE;
        2: pc_in = 8'h20;
        default: pc_in = 8'($urandom);
      endcase
      instr_ready = 1'($urandom);
      reuse_flush = ($urandom % 16) == 0;
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequences instruction fetch from the byte-wide, single-read-port instruction memory into the cpu.
- On a fetch request at a program counter, reads three consecutive bytes (opcode, arg1, arg2) over three cycles.
- Registers them and presents them to the cpu with a valid/ready handshake.
- Replaces ad-hoc per-cycle memory indexing; sits between the instruction memory and the cpu core.

Parameters:
ADDR_W, 8, instruction memory address width; the memory depth is 2^ADDR_W bytes.
DATA_W, 8, memory word width and width of op_code/arg1/arg2.

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst_n  in  1  synchronous active-low reset
pc_in  in  ADDR_W  address of the instruction to fetch
pc_req  in  1  fetch request; pc_in is sampled when pc_req=1
mem_addr  out  ADDR_W  instruction memory read address
mem_rd  out  1  read strobe; the memory returns mem_rdata one cycle after mem_rd=1
mem_rdata  in  DATA_W  memory read data
op_code  out  DATA_W  fetched opcode byte (mem[pc])
arg1  out  DATA_W  mem[pc+1]
arg2  out  DATA_W  mem[pc+2]
instr_valid  out  1  op_code/arg1/arg2 are valid
instr_ready  in  1  cpu accepts the instruction
busy  out  1  fetch in flight (states F0..W2)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; all outputs 0 (mem_addr, mem_rd, op_code, arg1, arg2, instr_valid, busy); the internal pc register is cleared. Reset takes priority over every other event, including mid-fetch; in-flight data is discarded.
- States: IDLE, F0, F1, F2, W2, HOLD. All outputs are registered.
- IDLE: pc_req=1 -> latch pc_in into pc_r; go to F0.
- F0: mem_rd=1, mem_addr=pc_r.
- F1: mem_rd=1, mem_addr=pc_r+1; capture mem_rdata into op_code.
- F2: mem_rd=1, mem_addr=pc_r+2; capture into arg1.
- W2: mem_rd=0; capture into arg2.
- HOLD: instr_valid=1.
- Latency: pc_req sampled at edge N -> mem_rd high in cycles N+1..N+3 -> instr_valid high from cycle N+5.
- Address arithmetic is mod 2^ADDR_W: pc_r=0xFE fetches 0xFE, 0xFF, 0x00.
- HOLD: op_code/arg1/arg2 stay stable until instr_valid && instr_ready. On that handshake:
  - pc_req=0: go to IDLE; instr_valid=0 in the next cycle.
  - pc_req=1 in the same cycle: latch pc_in and go straight to F0. Back-to-back throughput is one instruction per 5 cycles.
- Redirect: pc_req=1 in F0, F1, F2, W2, or in HOLD without instr_ready:
  - abort the current fetch and latch the new pc_in; go to F0 next cycle;
  - instr_valid=0 from the next cycle; discard bytes already in flight;
  - op_code/arg1/arg2 may change but are don't-care while instr_valid=0.
- busy=1 exactly in F0, F1, F2, W2.
- mem_rd=0 in IDLE, W2 and HOLD. mem_addr holds its last value when mem_rd=0.
- instr_ready while instr_valid=0 is ignored.

Optional Feature:
FETCH_REUSE_EN
- Defined:
  - Keep a one-entry buffer holding the last completed instruction (tag=pc, three bytes, tag_valid), written on entry to HOLD.
  - Add input port reuse_flush (1 bit): clears tag_valid; use it when instruction memory is rewritten.
  - pc_req in IDLE, at a HOLD handshake, or on a redirect, with tag_valid && pc_in==tag: load the buffered bytes and go directly to HOLD. instr_valid rises at N+1; no mem_rd is issued.
  - A miss behaves exactly as without the feature.
  - Reset clears tag_valid.
- Undefined: there is no buffer and no reuse_flush port; every request performs three memory reads.

Test Plan:
- Memory mem[0x10..0x12]=A7,05,3C; rst_n low 2 cycles, then pc_req with pc_in=0x10 at edge N, instr_ready=1 -> mem_rd high N+1..N+3 with mem_addr 10,11,12; instr_valid=1 at N+5 with op_code=A7, arg1=05, arg2=3C; instr_valid=0 at N+6.
- Wrap-around: mem[FE]=11, mem[FF]=22, mem[00]=33, pc_in=0xFE -> mem_addr sequence FE,FF,00; instr_valid=1 with 11/22/33.
- Backpressure: instr_ready=0 for 4 cycles after instr_valid -> outputs stable at A7/05/3C for all 4 cycles; instr_ready=1 -> one handshake, then IDLE.
- Redirect: pc_req with pc_in=0x10, then pc_req with pc_in=0x20 two cycles later (in F1) -> addresses 10,11,20,21,22; only the 0x20 instruction becomes valid; no instr_valid pulse for 0x10.
- Reset mid-fetch: rst_n=0 during F2 -> next cycle all outputs 0, state IDLE, mem_rd=0; a later pc_req fetches normally with 5-cycle latency.
- FETCH_REUSE_EN defined: fetch 0x10, handshake, pc_req 0x10 again -> instr_valid at N+1 with A7/05/3C and no mem_rd. Pulse reuse_flush, then pc_req 0x10 -> full 3-read fetch.
